// File: rtl/seg_display_scan_if.sv
// Display/button bundle between the register file side and the 4-digit scan driver.
// The driver sits on the slave modport.
interface seg_display_scan_if;
  logic [15:0] Value;
  logic        Btn_Raw;
  logic        Btn_Db;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP;

  modport master (output Value, Btn_Raw, input Btn_Db, AN, SEG, DP);
  modport slave  (input Value, Btn_Raw, output Btn_Db, AN, SEG, DP);
endinterface

// File: rtl/seg_display_scan.sv
// Four-digit multiplexed seven-segment driver with a per-frame snapshot of the display word.
// It also synchronises and debounces the half-select push-button.
module seg_display_scan #(
  parameter int REFRESH_DIV  = 100000,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter bit BLANK_LZ     = 1'b0
) (
  input  logic CLK,
  input  logic RST_N,
  seg_display_scan_if.slave dsp
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYC);
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYC - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          s1_q, s2_q;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          db_q, db_d;
  logic          tick, hi_zero;
  logic [3:0]    nib;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    tick     = (presc_q == PMAX);
    presc_d  = tick ? '0 : presc_q + 1'b1;
    idx_d    = tick ? idx_q + 2'd1 : idx_q;
    // Snapshot only at the end of digit 3 so a frame never mixes two words.
    shadow_d = (tick && idx_q == 2'd3) ? dsp.Value : shadow_q;

    case (idx_q)
      2'd0:    begin nib = shadow_q[3:0];   hi_zero = 1'b0;                    end
      2'd1:    begin nib = shadow_q[7:4];   hi_zero = (shadow_q[15:4] == '0);  end
      2'd2:    begin nib = shadow_q[11:8];  hi_zero = (shadow_q[15:8] == '0);  end
      default: begin nib = shadow_q[15:12]; hi_zero = (shadow_q[15:12] == '0); end
    endcase

    an_d  = ~(4'b0001 << idx_q);
    seg_d = (BLANK_LZ && hi_zero) ? 7'b1111111 : hex7(nib);
    dp_d  = ~(idx_q == 2'd0 && db_q);

    // Debounce: any return to the current output level restarts the count.
    db_d   = db_q;
    dcnt_d = '0;
    if (s2_q != db_q) begin
      if (dcnt_q == DMAX) db_d = s2_q;
      else                dcnt_d = dcnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      presc_q  <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      an_q     <= 4'b1111;
      seg_q    <= 7'b1111111;
      dp_q     <= 1'b1;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      dcnt_q   <= '0;
      db_q     <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      s1_q     <= dsp.Btn_Raw;
      s2_q     <= s1_q;
      dcnt_q   <= dcnt_d;
      db_q     <= db_d;
    end
  end

  assign dsp.AN     = an_q;
  assign dsp.SEG    = seg_q;
  assign dsp.DP     = dp_q;
  assign dsp.Btn_Db = db_q;
endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan at REFRESH_DIV=4, DEBOUNCE_CYC=8.
// dut_a runs without blanking, dut_b with leading-zero blanking; both see the same stimulus.
module tb_seg_display_scan;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  seg_display_scan_if ifa();
  seg_display_scan_if ifb();

  seg_display_scan #(.REFRESH_DIV(4), .DEBOUNCE_CYC(8), .BLANK_LZ(1'b0)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .dsp(ifa));
  seg_display_scan #(.REFRESH_DIV(4), .DEBOUNCE_CYC(8), .BLANK_LZ(1'b1)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .dsp(ifb));

  logic [6:0] SEGTAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Word on display during each 16-cycle frame of the scan phase.
  logic [15:0] FW [7] = '{16'h0000, 16'h1234, 16'hABCD, 16'hABCD,
                          16'h00F0, 16'h00F0, 16'h0000};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_val(input logic [15:0] v);
    ifa.Value = v;
    ifb.Value = v;
  endtask

  task automatic set_btn(input logic b);
    ifa.Btn_Raw = b;
    ifb.Btn_Raw = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, n;
    logic [15:0] w, sh;
    logic [3:0] an_e;
    logic [6:0] seg_e, segb_e;
    logic dp_e;

    set_val(16'h1234);
    set_btn(1'b0);
    RST_N = 1'b0;
    cyc(); cyc();
    chk("rst_AN",  ifa.AN,  4'b1111);
    chk("rst_SEG", ifa.SEG, 7'b1111111);
    chk("rst_DP",  ifa.DP,  1'b1);
    chk("rst_Db",  ifa.Btn_Db, 1'b0);
    chk("rst_AN_b", ifb.AN, 4'b1111);

    RST_N = 1'b1;
    for (int k = 1; k <= 112; k++) begin
      cyc();
      d = ((k - 1) / 4) % 4;
      w = FW[(k - 1) / 16];
      sh = w >> (4 * d);
      an_e = ~(4'b0001 << d);
      seg_e = SEGTAB[sh[3:0]];
      segb_e = (d > 0 && sh == 16'h0) ? 7'b1111111 : seg_e;
      chk("scan_AN",    ifa.AN,  an_e);
      chk("scan_SEG",   ifa.SEG, seg_e);
      chk("scan_DP",    ifa.DP,  1'b1);
      chk("blank_AN",   ifb.AN,  an_e);
      chk("blank_SEG",  ifb.SEG, segb_e);
      if (k == 21) set_val(16'hABCD);
      if (k == 52) set_val(16'h00F0);
      if (k == 84) set_val(16'h0000);
    end

    for (int i = 0; i < 30; i++) begin
      set_btn(((i / 3) % 2) == 0);
      cyc();
      chk("bounce_Db", ifa.Btn_Db, 1'b0);
    end
    set_btn(1'b1);
    n = 0;
    while (ifa.Btn_Db !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    chk("db_latency", 16'(n >= 9 && n <= 11), 16'd1);

    cyc(); cyc();
    for (int i = 0; i < 16; i++) begin
      cyc();
      dp_e = (ifa.AN == 4'b1110) ? 1'b0 : 1'b1;
      chk("dp_sel", ifa.DP, dp_e);
    end

    // Align to the first cycle of digit 2 so the internal index is still 2.
    n = 0;
    while (ifa.AN === 4'b1011 && n < 20) begin cyc(); n++; end
    while (ifa.AN !== 4'b1011 && n < 40) begin cyc(); n++; end
    chk("find_idx2", ifa.AN, 4'b1011);
    chk("db_before_rst", ifa.Btn_Db, 1'b1);
    RST_N = 1'b0;
    cyc();
    chk("midrst_AN",  ifa.AN,  4'b1111);
    chk("midrst_SEG", ifa.SEG, 7'b1111111);
    chk("midrst_DP",  ifa.DP,  1'b1);
    chk("midrst_Db",  ifa.Btn_Db, 1'b0);
    RST_N = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      an_e = (k <= 4) ? 4'b1110 : 4'b1101;
      chk("restart_AN",  ifa.AN,  an_e);
      chk("restart_SEG", ifa.SEG, 7'b1000000);
      chk("restart_Db",  ifa.Btn_Db, 1'b0);
    end
    n = 8;
    while (ifa.Btn_Db !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    chk("db_reassert", 16'(n >= 9 && n <= 11), 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
